// File: rtl/red_pkg.sv
// Shared types and the reference arithmetic for the RED byte-lane reduction.
package red_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPairAb  = 3'd1,
        StPairCd  = 3'd2,
        StCombine = 3'd3,
        StDone    = 3'd4
    } red_state_t;

    // 12-bit extension of a 9-bit pair sum: bits 11:9 replicate bit 7, not bit 8.
    function automatic logic [11:0] red_x(input logic [8:0] v);
        return {v[7], v[7], v[7], v};
    endfunction

    // Bit-exact reference for the whole reduction.
    function automatic logic [15:0] red_ref(input logic [15:0] rs, input logic [15:0] rt);
        logic [8:0] ab;
        logic [8:0] cd;
        logic [9:0] s;
        ab = {1'b0, rs[15:8]} + {1'b0, rs[7:0]};
        cd = {1'b0, rt[15:8]} + {1'b0, rt[7:0]};
        // Only S[9:0] reaches the result, so the sum is taken mod 1024.
        s  = {ab[7], ab} + {cd[7], cd};
        return {{6{s[9]}}, s};
    endfunction

endpackage

// File: rtl/carry_look_ahead.sv
// 4-bit carry-lookahead adder slice.
module carry_look_ahead (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate and flattened lookahead carries.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/red_adder12.sv
// Shared 12-bit adder with its state-driven operand mux.
module red_adder12 import red_pkg::*; (
    input  red_state_t  state,
    input  logic [15:0] op_rs,
    input  logic [15:0] op_rt,
    input  logic [8:0]  ab,
    input  logic [8:0]  cd,
    output logic [11:0] res
);

    logic [11:0] op_a;
    logic [11:0] op_b;
    logic        c4;
    logic        c8;
    logic        unused_cout;

    // Pair states add zero-extended bytes; COMBINE adds the extended pair sums.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state)
            StPairAb: begin
                op_a = {4'h0, op_rs[15:8]};
                op_b = {4'h0, op_rs[7:0]};
            end
            StPairCd: begin
                op_a = {4'h0, op_rt[15:8]};
                op_b = {4'h0, op_rt[7:0]};
            end
            StCombine: begin
                op_a = red_x(ab);
                op_b = red_x(cd);
            end
            default: begin
                op_a = '0;
                op_b = '0;
            end
        endcase
    end

    carry_look_ahead u_cla_lo (
        .a    (op_a[3:0]),
        .b    (op_b[3:0]),
        .cin  (1'b0),
        .s    (res[3:0]),
        .cout (c4)
    );

    carry_look_ahead u_cla_mid (
        .a    (op_a[7:4]),
        .b    (op_b[7:4]),
        .cin  (c4),
        .s    (res[7:4]),
        .cout (c8)
    );

    carry_look_ahead u_cla_hi (
        .a    (op_a[11:8]),
        .b    (op_b[11:8]),
        .cin  (c8),
        .s    (res[11:8]),
        .cout (unused_cout)
    );

endmodule

// File: rtl/red_seq.sv
// Multi-cycle RED reduction: one shared adder stepped through AB, CD, COMBINE.
module red_seq import red_pkg::*; (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] rs,
    input  logic [15:0] rt,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sum,
    output logic        busy
);

    red_state_t  state_q;
    red_state_t  state_d;
    logic [15:0] rs_q;
    logic [15:0] rt_q;
    logic [8:0]  reg_ab;
    logic [8:0]  reg_cd;
    logic [15:0] sum_q;
    logic [11:0] add_res;
    logic        accept;
    logic        unused_add_hi;

    assign accept        = (state_q == StIdle) && in_valid && !flush;
    assign unused_add_hi = ^add_res[11:10];

    red_adder12 u_adder (
        .state (state_q),
        .op_rs (rs_q),
        .op_rt (rt_q),
        .ab    (reg_ab),
        .cd    (reg_cd),
        .res   (add_res)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: flush squashes any non-idle state; DONE waits for out_ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StPairAb;
            StPairAb:  state_d = flush ? StIdle : StPairCd;
            StPairCd:  state_d = flush ? StIdle : StCombine;
            StCombine: state_d = flush ? StIdle : StDone;
            StDone:    if (flush || out_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Operand capture and per-step result capture from the shared adder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q   <= '0;
            rt_q   <= '0;
            reg_ab <= '0;
            reg_cd <= '0;
            sum_q  <= '0;
        end else begin
            if (accept) begin
                rs_q <= rs;
                rt_q <= rt;
            end
            if (state_q == StPairAb) reg_ab <= add_res[8:0];
            if (state_q == StPairCd) reg_cd <= add_res[8:0];
            if (state_q == StCombine && !flush) sum_q <= {{6{add_res[9]}}, add_res[9:0]};
        end
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        sum       = sum_q;
    end

endmodule
